bcd_scan_driver: RTL and testbench

//   Consumes the six 4-bit display codes (bch0..bch5) and the alarm flag from the clock

---
 rtl/bcd_scan_driver.sv | 159 +++++++++++++++
 tb/tb_bcd_scan_driver.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver
//   Multiplexed driver for a 6-digit common-anode 7-segment display. Input codes are
//   captured into shadow registers once per frame so a digit never changes mid-scan.
//   A guard interval at the start of every slot blanks all digits to avoid ghosting.
//   The alarm flash and colon blink are overlaid on the registered outputs.
//
// Ports
//   clk          system clock
//   reset        asynchronous active-low reset
//   bch0..bch5   4-bit display codes, bch0 = leftmost digit
//   alarmAlert   alarm ringing; flash the whole display
//   real_quarter blink phase, 1 = visible phase
//   seg          segments {g,f,e,d,c,b,a}
//   dp           decimal point / colon dot
//   digit_sel    one-hot digit enable, bit k = digit k
//   frame_done   single-cycle pulse after the shadow registers reload

module bcd_scan_driver #(
  parameter int unsigned SCAN_DIV         = 1000,
  parameter int unsigned GUARD            = 2,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1,
  parameter bit          DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] bch0,
  input  logic [3:0] bch1,
  input  logic [3:0] bch2,
  input  logic [3:0] bch3,
  input  logic [3:0] bch4,
  input  logic [3:0] bch5,
  input  logic       alarmAlert,
  input  logic       real_quarter,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] digit_sel,
  output logic       frame_done
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] GuardVal = CntW'(GUARD);
  localparam logic [6:0] SegOff = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DpOff  = SEG_ACTIVE_LOW;
  localparam logic [5:0] DigOff = DIGIT_ACTIVE_LOW ? 6'h3F : 6'h00;
  localparam logic [3:0] CodeBlank = 4'd10;

  // Active-high segment pattern for a display code.
  function automatic logic [6:0] decode(input logic [3:0] code);
    unique case (code)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      4'd11:   return 7'h40;
      4'd12:   return 7'h77;
      4'd13:   return 7'h73;
      4'd14:   return 7'h79;
      default: return 7'h00;  // 10 and 15 are blank
    endcase
  endfunction

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [3:0]      shadow_q [6];
  logic [3:0]      shadow_d [6];
  logic [3:0]      bch      [6];
  logic            frame_done_q, frame_done_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [5:0]      digit_sel_q, digit_sel_d;

  logic cnt_wrap, idx_ok, reload;

  always_comb begin
    bch[0] = bch0;
    bch[1] = bch1;
    bch[2] = bch2;
    bch[3] = bch3;
    bch[4] = bch4;
    bch[5] = bch5;
  end

  // Prescaler, digit index and frame buffer next state.
  always_comb begin
    cnt_wrap = (cnt_q == CntMax);
    idx_ok   = (idx_q <= 3'd5);
    reload   = cnt_wrap && (idx_q == 3'd5);

    cnt_d = cnt_wrap ? '0 : cnt_q + CntW'(1);

    idx_d = idx_q;
    if (!idx_ok) begin
      idx_d = 3'd0;  // unreachable codes recover immediately
    end else if (cnt_wrap) begin
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end

    shadow_d = shadow_q;
    if (reload) begin
      shadow_d = bch;
    end
    frame_done_d = reload;
  end

  // Output next state, one cycle behind (cnt, idx, shadow).
  always_comb begin
    logic       selected;
    logic       flash_off;
    logic [3:0] code;
    logic [6:0] pat;
    logic       dp_on;
    logic [5:0] hot;

    selected  = idx_ok && (cnt_q >= GuardVal);
    flash_off = alarmAlert && !real_quarter;
    code      = idx_ok ? shadow_q[idx_q] : CodeBlank;
    hot       = 6'd1 << idx_q;

    pat   = (selected && !flash_off) ? decode(code) : 7'h00;
    dp_on = selected && !flash_off && real_quarter && ((idx_q == 3'd1) || (idx_q == 3'd3));

    seg_d       = pat ^ {7{SEG_ACTIVE_LOW}};
    dp_d        = dp_on ^ SEG_ACTIVE_LOW;
    digit_sel_d = (selected ? hot : 6'h00) ^ {6{DIGIT_ACTIVE_LOW}};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      for (int k = 0; k < 6; k++) shadow_q[k] <= CodeBlank;
      frame_done_q <= 1'b0;
      seg_q        <= SegOff;
      dp_q         <= DpOff;
      digit_sel_q  <= DigOff;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      digit_sel_q  <= digit_sel_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_sel  = digit_sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_scan_driver.sv
module tb_bcd_scan_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] bch0, bch1, bch2, bch3, bch4, bch5;
  logic       alarmAlert, real_quarter;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] digit_sel;
  logic       frame_done;

  always #5 clk = ~clk;

  bcd_scan_driver #(
    .SCAN_DIV        (4),
    .GUARD           (1),
    .SEG_ACTIVE_LOW  (1'b1),
    .DIGIT_ACTIVE_LOW(1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bch0        (bch0),
    .bch1        (bch1),
    .bch2        (bch2),
    .bch3        (bch3),
    .bch4        (bch4),
    .bch5        (bch5),
    .alarmAlert  (alarmAlert),
    .real_quarter(real_quarter),
    .seg         (seg),
    .dp          (dp),
    .digit_sel   (digit_sel),
    .frame_done  (frame_done)
  );

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [5:0] ds;
    logic       fd;
  } exp_t;

  typedef struct {
    logic [3:0]  b0, b1, b2, b3, b4, b5;
    logic        alarm;
    logic        rq;
    int unsigned cycles;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[5];

  int n_chk = 0;
  int n_fail = 0;
  int fd_seen = 0;

  // Reference model state: prescaler, slot index, frame buffer.
  int         m_cnt;
  int         m_idx;
  logic [3:0] m_sh[6];

  function automatic logic [6:0] dec(input logic [3:0] c);
    case (c)
      4'd0:  return 7'h3F;
      4'd1:  return 7'h06;
      4'd2:  return 7'h5B;
      4'd3:  return 7'h4F;
      4'd4:  return 7'h66;
      4'd5:  return 7'h6D;
      4'd6:  return 7'h7D;
      4'd7:  return 7'h07;
      4'd8:  return 7'h7F;
      4'd9:  return 7'h6F;
      4'd11: return 7'h40;
      4'd12: return 7'h77;
      4'd13: return 7'h73;
      4'd14: return 7'h79;
      default: return 7'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_idx = 0;
    for (int k = 0; k < 6; k++) m_sh[k] = 4'd10;
  endtask

  // One clock: predict, push, clock, update model, pop and compare on the falling edge.
  task automatic step();
    exp_t       e;
    exp_t       got;
    logic [3:0] b[6];
    logic       sel;
    logic [6:0] pat;
    logic       dp_on;
    b     = '{bch0, bch1, bch2, bch3, bch4, bch5};
    sel   = (m_cnt >= 1);
    pat   = sel ? dec(m_sh[m_idx]) : 7'h00;
    dp_on = sel && real_quarter && (m_idx == 1 || m_idx == 3);
    if (alarmAlert && !real_quarter) begin
      pat   = 7'h00;
      dp_on = 1'b0;
    end
    e.seg = ~pat;
    e.dp  = ~dp_on;
    e.ds  = sel ? ~(6'(1 << m_idx)) : 6'h3F;
    e.fd  = (m_cnt == 3 && m_idx == 5);
    sbq.push_back(e);
    @(posedge clk);
    if (m_cnt == 3 && m_idx == 5) m_sh = b;
    if (m_cnt == 3) begin
      m_cnt = 0;
      m_idx = (m_idx == 5) ? 0 : m_idx + 1;
    end else begin
      m_cnt++;
    end
    @(negedge clk);
    if (frame_done) fd_seen++;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 16'd1, 16'd0);
    end else begin
      got = sbq.pop_front();
      chk("scan", {1'b0, seg, dp, digit_sel, frame_done},
          {1'b0, got.seg, got.dp, got.ds, got.fd});
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic sync_frame();
    for (int i = 0; i < 30; i++) begin
      if (m_cnt == 0 && m_idx == 0) break;
      step();
    end
  endtask

  task automatic set_bch(input logic [3:0] a0, a1, a2, a3, a4, a5);
    bch0 = a0; bch1 = a1; bch2 = a2; bch3 = a3; bch4 = a4; bch5 = a5;
  endtask

  initial begin
    vecs[0] = '{b0: 4'd1,  b1: 4'd2,  b2: 4'd3,  b3: 4'd4,  b4: 4'd5,  b5: 4'd6,
                alarm: 1'b0, rq: 1'b1, cycles: 48};
    vecs[1] = '{b0: 4'd13, b1: 4'd10, b2: 4'd12, b3: 4'd11, b4: 4'd14, b5: 4'd15,
                alarm: 1'b0, rq: 1'b1, cycles: 48};
    vecs[2] = '{b0: 4'd0,  b1: 4'd7,  b2: 4'd9,  b3: 4'd8,  b4: 4'd3,  b5: 4'd2,
                alarm: 1'b0, rq: 1'b0, cycles: 48};
    vecs[3] = '{b0: 4'd0,  b1: 4'd7,  b2: 4'd9,  b3: 4'd8,  b4: 4'd3,  b5: 4'd2,
                alarm: 1'b1, rq: 1'b1, cycles: 24};
    vecs[4] = '{b0: 4'd5,  b1: 4'd5,  b2: 4'd5,  b3: 4'd5,  b4: 4'd5,  b5: 4'd5,
                alarm: 1'b1, rq: 1'b0, cycles: 24};

    set_bch(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    alarmAlert   = 1'b0;
    real_quarter = 1'b1;
    reset        = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_dp", 16'(dp), 16'h1);
    chk("rst_digit_sel", 16'(digit_sel), 16'h3F);
    chk("rst_frame_done", 16'(frame_done), 16'h0);

    // First frame after reset is blank even with real codes applied.
    model_reset();
    set_bch(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    reset = 1'b1;
    run(2);
    chk("first_frame_ds", 16'(digit_sel), 16'h3E);
    chk("first_frame_seg", 16'(seg), 16'h7F);
    run(22);

    // Second frame: guard, digit 0 shows 1, digit 1 shows 2 with colon.
    sync_frame();
    run(1);
    chk("guard_ds", 16'(digit_sel), 16'h3F);
    run(1);
    chk("d0_ds", 16'(digit_sel), 16'h3E);
    chk("d0_seg", 16'(seg), 16'h79);
    chk("d0_dp", 16'(dp), 16'h1);
    run(4);
    chk("d1_ds", 16'(digit_sel), 16'h3D);
    chk("d1_seg", 16'(seg), 16'h24);
    chk("d1_dp", 16'(dp), 16'h0);

    // Mid-frame input change is deferred to the next reload.
    run(2);
    bch2 = 4'd8;
    run(2);
    chk("d2_old_ds", 16'(digit_sel), 16'h3B);
    chk("d2_old_seg", 16'(seg), 16'h30);
    run(24);
    chk("d2_new_seg", 16'(seg), 16'h00);
    fd_seen = 0;
    run(48);
    chk("frame_done_count", 16'(fd_seen), 16'd2);

    // Table of static patterns.
    for (int v = 0; v < 5; v++) begin
      set_bch(vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3, vecs[v].b4, vecs[v].b5);
      alarmAlert   = vecs[v].alarm;
      real_quarter = vecs[v].rq;
      run(int'(vecs[v].cycles));
    end

    // Alarm flash with blink phase toggling at an odd cadence.
    set_bch(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    alarmAlert = 1'b1;
    for (int i = 0; i < 60; i++) begin
      real_quarter = ((i / 3) % 2) == 0;
      step();
    end
    alarmAlert   = 1'b0;
    real_quarter = 1'b1;
    run(24);

    // Asynchronous reset during the digit 3 slot.
    sync_frame();
    run(14);
    chk("pre_rst_ds", 16'(digit_sel), 16'h37);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_seg", 16'(seg), 16'h7F);
    chk("async_rst_dp", 16'(dp), 16'h1);
    chk("async_rst_ds", 16'(digit_sel), 16'h3F);
    chk("async_rst_fd", 16'(frame_done), 16'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    run(2);
    chk("post_rst_ds", 16'(digit_sel), 16'h3E);
    chk("post_rst_seg", 16'(seg), 16'h7F);
    run(22);
    run(24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
